// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with a one-byte hold register, an edge-triggered
//            consume input, a sticky overrun flag and an optional stop-bit
//            check enabled by the macro UART_RX_FRAME_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_Rx_Serial,
  input  logic       i_Rx_Next,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Overrun,
  output logic       o_Rx_FrameErr
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          dv_q, dv_d;
  logic          ovr_q, ovr_d;
  logic          rx_meta_q, rx_s_q;
  logic          next_q;
  logic          stop_done;
  logic          frame_ok;
  logic          consume;

  // Frame decoder: mid-bit sampling driven by a single cycle counter.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    stop_done = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (clk_cnt_q == HALF_CNT) begin
          clk_cnt_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt_q == FULL_CNT) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt_q == FULL_CNT) begin
          clk_cnt_d = '0;
          stop_done = 1'b1;
          state_d   = IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_FRAME_ERR_EN
  assign frame_ok = rx_s_q;
`else
  assign frame_ok = 1'b1;
`endif

  assign consume = i_Rx_Next && !next_q && dv_q;

  // A consume coinciding with completion hands over straight to the new byte.
  always_comb begin
    dv_d   = dv_q;
    byte_d = byte_q;
    ovr_d  = ovr_q;
    if (stop_done && frame_ok) begin
      if (!dv_q || consume) begin
        byte_d = shift_q;
        dv_d   = 1'b1;
        ovr_d  = 1'b0;
      end else begin
        ovr_d  = 1'b1;
      end
    end else if (consume) begin
      dv_d  = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      next_q    <= 1'b1;
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
      next_q    <= i_Rx_Next;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  logic fe_q;

  always_ff @(posedge clk) begin
    if (rst) fe_q <= 1'b0;
    else     fe_q <= stop_done && !rx_s_q;
  end

  assign o_Rx_FrameErr = fe_q;
`else
  assign o_Rx_FrameErr = 1'b0;
`endif

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Byte    = byte_q;
  assign o_Rx_Overrun = ovr_q;

endmodule
`default_nettype wire
